psum_sram_reader: RTL

- Read-side engine for the psum SRAM written by the core datapath.
- On a start command it walks a contiguous address range of the psum SRAM and drives the SRAM control pins (CEN/WEN/A).
- It captures each read word and streams the words out over a valid/ready interface to the testbench or downstream verification logic.
- A 2-entry output buffer plus read-credit tracking gives 1 word/cycle throughput under full backpressure tolerance, with no lost or duplicated words.

---
 rtl/psum_sram_reader_if.sv | 30 +++
 rtl/psum_sram_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/psum_sram_reader_if.sv
// Bus bundle for psum_sram_reader: SRAM read-port pins plus the valid/ready output stream.
// The reader drives it through the master modport; the SRAM and the sink use the slave modport.
interface psum_sram_reader_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int aw      = 10
) ();
    logic                   sram_cen;
    logic                   sram_wen;
    logic [aw-1:0]          sram_a;
    logic [col*psum_bw-1:0] sram_q;
    logic                   out_valid;
    logic                   out_ready;
    logic [col*psum_bw-1:0] out_data;
    logic                   out_last;

    modport master (
        output sram_cen, sram_wen, sram_a,
        input  sram_q,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_cen, sram_wen, sram_a,
        output sram_q,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_sram_reader.sv
// Walks a contiguous psum SRAM range and streams each word out over valid/ready.
// Optional macro PSUM_RELU_EN zeroes every negative psum lane on the output side.
module psum_sram_reader #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int aw      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [aw-1:0]      base_addr,
    input  logic [aw:0]        count,
    output logic               busy,
    output logic               done,
    psum_sram_reader_if.master bus
);
    localparam int W = col * psum_bw;
    localparam logic [aw:0]   LEFT_ONE = {{aw{1'b0}}, 1'b1};
    localparam logic [aw-1:0] ADDR_ONE = {{(aw-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [aw-1:0] last_a_q, last_a_d;
    logic [aw:0]   left_q, left_d;
    logic          in_flight_q, in_flight_d;
    logic          in_flight_last_q, in_flight_last_d;
    logic          zero_done_q, zero_done_d;
    logic [W-1:0]  buf_data_q [2];
    logic [W-1:0]  buf_data_d [2];
    logic [1:0]    buf_last_q, buf_last_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    occ_q, occ_d;

    logic          issue;
    logic          pop;
    logic          capture;
    logic          drain_done;
    logic [1:0]    pending;
    logic [W-1:0]  head_data;

    always_comb begin
        pop        = (occ_q != 2'd0) && bus.out_ready;
        capture    = in_flight_q;
        pending    = occ_q + {1'b0, in_flight_q};
        // Buffered plus in-flight words never exceed the two buffer slots.
        issue      = (state_q == ISSUE) &&
                     ((pending < 2'd2) || ((pending == 2'd2) && pop));
        drain_done = (state_q == DRAIN) && (occ_q == 2'd0) && !in_flight_q;

        state_d          = state_q;
        addr_d           = addr_q;
        last_a_d         = last_a_q;
        left_d           = left_q;
        zero_done_d      = 1'b0;
        in_flight_d      = issue;
        in_flight_last_d = issue && (left_q == LEFT_ONE);
        buf_data_d       = buf_data_q;
        buf_last_d       = buf_last_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = base_addr;
                        left_d  = count;
                    end
                end
            end
            ISSUE: begin
                if (issue && (left_q == LEFT_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            addr_d   = addr_q + ADDR_ONE;
            last_a_d = addr_q;
            left_d   = left_q - LEFT_ONE;
        end

        if (capture) begin
            buf_data_d[wr_ptr_q] = bus.sram_q;
            buf_last_d[wr_ptr_q] = in_flight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            last_a_q         <= '0;
            left_q           <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            zero_done_q      <= 1'b0;
            buf_data_q[0]    <= '0;
            buf_data_q[1]    <= '0;
            buf_last_q       <= '0;
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            occ_q            <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            last_a_q         <= last_a_d;
            left_q           <= left_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
            zero_done_q      <= zero_done_d;
            buf_data_q[0]    <= buf_data_d[0];
            buf_data_q[1]    <= buf_data_d[1];
            buf_last_q       <= buf_last_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            occ_q            <= occ_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = zero_done_q | drain_done;
    assign bus.sram_cen  = ~issue;
    assign bus.sram_wen  = 1'b1;
    // The address pins keep showing the last issued address between reads.
    assign bus.sram_a    = issue ? addr_q : last_a_q;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_last  = bus.out_valid & buf_last_q[rd_ptr_q];
    assign head_data     = bus.out_valid ? buf_data_q[rd_ptr_q] : '0;

`ifdef PSUM_RELU_EN
    logic [W-1:0] relu_data;

    always_comb begin
        relu_data = head_data;
        for (int l = 0; l < col; l++) begin
            if (head_data[l*psum_bw + psum_bw - 1]) begin
                relu_data[l*psum_bw +: psum_bw] = '0;
            end
        end
    end

    assign bus.out_data = relu_data;
`else
    assign bus.out_data = head_data;
`endif

endmodule
